tlu_trigger_handshake_fsm: RTL and testbench
============================================

# tlu_trigger_handshake_fsm

Parametrised trigger controller between a synchronised TLU trigger input and the command FSM and readout FIFO. It generalises the trigger number width and timeout width, and adds:

- internal rising-edge detection;
- an integrated serial trigger-number receiver that drives TLU_CLOCK;
- an internal trigger counter;
- a valid/ready data handshake to readout;
- a saturating abort counter.

## Interface
- TRIGGER_ID_WIDTH, 15: width of the trigger number, both serial and internal (1..31).
- TIMEOUT_WIDTH, 8: width of the trigger-low timeout counter.
- DIVIDER, 4: number of CLK cycles per TLU_CLOCK half-period (≥1).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high.
- TLU_MODE  in  2  00 command only; 01 no handshake + internal ID; 10 simple handshake + internal ID; 11 data handshake + serial ID.
- TIMEOUT  in  TIMEOUT_WIDTH  trigger-low timeout in cycles; 0 disables.
- TLU_TRIGGER  in  1  trigger, already synchronised to CLK.
- TLU_TRIGGER_DATA  in  1  serial trigger number (TLU reset line), synchronised.
- TLU_BUSY  out  1  busy/veto to TLU.
- TLU_CLOCK  out  1  serial clock to TLU.
- CMD_READY  in  1  command FSM idle.
- CMD_EXT_START_ENABLE  in  1  external triggering enabled.
- CMD_EXT_START_FLAG  out  1  one-cycle command start pulse.
- FIFO_NEAR_FULL  in  1  blocks new triggers.
- TRIGGER_DATA  out  TRIGGER_ID_WIDTH  trigger number to readout.
- TRIGGER_DATA_VALID  out  1  data valid.
- TRIGGER_DATA_READY  in  1  readout accepts data.
- TRIGGER_ABORT  out  1  one-cycle pulse on timeout.
- ABORT_CNT  out  16  aborted triggers, saturating.

## Operation
- accept = CMD_READY & CMD_EXT_START_ENABLE & ~FIFO_NEAR_FULL.
- rise = TLU_TRIGGER & ~trig_q, where trig_q is TLU_TRIGGER delayed by one cycle.

States and transitions:
- IDLE → SEND_COMMAND on rise & accept. Otherwise stay in IDLE, and the edge is dropped, not queued. Edges outside IDLE are ignored.
- SEND_COMMAND (1 cycle): increment the internal counter (wraps at 2^TRIGGER_ID_WIDTH) and load it into TRIGGER_DATA.
  - mode 00 → WAIT_FOR_CMD
  - mode 01 → WAIT_FOR_READOUT
  - mode 1x → WAIT_FOR_TRIGGER_LOW
- WAIT_FOR_TRIGGER_LOW:
  - The timeout counter clears on entry and increments each cycle.
  - Abort condition: TLU_TRIGGER=1 & TIMEOUT≠0 & count==TIMEOUT−1. Effect: pulse TRIGGER_ABORT, increment ABORT_CNT (holds at 0xFFFF), go to IDLE. No data is emitted.
  - Else on TLU_TRIGGER=0: mode 10 → WAIT_FOR_READOUT; mode 11 → RECEIVE_DATA.
- RECEIVE_DATA:
  - TRIGGER_ID_WIDTH periods of TLU_CLOCK; each period is DIVIDER cycles high, then DIVIDER cycles low.
  - On the last low cycle of each period, shift TLU_TRIGGER_DATA into the MSB of the shift register, shifting right (LSB first).
  - After the final bit, load the shift register into TRIGGER_DATA → WAIT_FOR_READOUT.
- WAIT_FOR_READOUT: TRIGGER_DATA_VALID=1; on TRIGGER_DATA_READY=1 in the same cycle → WAIT_FOR_CMD.
- WAIT_FOR_CMD: on CMD_READY=1 → IDLE.
- A TLU_MODE change is only honoured at decision points. Software must change it only while CMD_EXT_START_ENABLE=0.

Output rules:
- TLU_BUSY:
  - modes 1x: 1 in every state except IDLE; in IDLE, TLU_BUSY = ~accept.
  - modes 0x: held 0.
- TLU_CLOCK is 0 outside RECEIVE_DATA.
- All outputs are registered and reflect the current state.

## Timing
- Reset values: TLU_BUSY=1, TLU_CLOCK=0, CMD_EXT_START_FLAG=0, TRIGGER_DATA=0, TRIGGER_DATA_VALID=0, TRIGGER_ABORT=0, ABORT_CNT=0. Internal counter, shift register and timeout counter are 0; state is IDLE.
- Reset asserted mid-operation: immediate return to these values. A transfer in flight is lost.
- TLU_TRIGGER first sampled high at cycle n (low at n−1):
  - CMD_EXT_START_FLAG=1 at cycle n+1 only.
  - TLU_BUSY=1 from n+1 (modes 1x).
- Mode 10, trigger low sampled at cycle m: TRIGGER_DATA_VALID=1 from m+1.
- Mode 11, trigger low sampled at cycle m:
  - TLU_CLOCK rises at m+1.
  - TRIGGER_DATA_VALID=1 at m+1+2·DIVIDER·TRIGGER_ID_WIDTH.
- VALID/DATA are held stable until the READY cycle; VALID drops the cycle after.
- With READY and CMD_READY both high, return to IDLE takes 2 cycles after VALID.
- Timeout: with TIMEOUT=T and TLU_TRIGGER stuck high, TRIGGER_ABORT pulses at the T-th cycle in WAIT_FOR_TRIGGER_LOW. TLU_BUSY is 0 the cycle after, if accept holds.

## Test plan
- Mode 00, rising edge on TLU_TRIGGER → one-cycle CMD_EXT_START_FLAG; TLU_BUSY stays 0; TRIGGER_DATA_VALID never asserts; back in IDLE once CMD_READY=1.
- Mode 10, three triggers, READY tied high → TRIGGER_DATA = 1, 2, 3; TLU_BUSY high from edge+1 until return to IDLE.
- Mode 11, W=15, DIVIDER=4, TLU model returning 0x2A5B → TRIGGER_DATA=0x2A5B; exactly 15 TLU_CLOCK pulses; VALID 120 cycles after trigger low.
- Mode 10, TIMEOUT=10, trigger held high 50 cycles → TRIGGER_ABORT pulse at cycle 10 in WAIT_FOR_TRIGGER_LOW; ABORT_CNT=1; no VALID; a subsequent trigger yields TRIGGER_DATA=2.
- FIFO_NEAR_FULL=1 or CMD_EXT_START_ENABLE=0 with a trigger edge → no CMD_EXT_START_FLAG, TLU_BUSY=1 (mode 1x); the edge is not replayed when the block is unblocked.
- Mode 11, RESET asserted at bit 7 of reception, then a new trigger → all outputs at reset values immediately; the next transfer is complete and correct.

Source files
------------

// File: rtl/tlu_trigger_handshake_fsm_if.sv
// Signal bundle between the TLU trigger controller (master) and its environment:
// TLU lines, command FSM hand-off and the readout data handshake.
interface tlu_trigger_handshake_fsm_if #(
    parameter int TRIGGER_ID_WIDTH = 15,
    parameter int TIMEOUT_WIDTH    = 8
);
    logic [1:0]                  TLU_MODE;
    logic [TIMEOUT_WIDTH-1:0]    TIMEOUT;
    logic                        TLU_TRIGGER;
    logic                        TLU_TRIGGER_DATA;
    logic                        TLU_BUSY;
    logic                        TLU_CLOCK;
    logic                        CMD_READY;
    logic                        CMD_EXT_START_ENABLE;
    logic                        CMD_EXT_START_FLAG;
    logic                        FIFO_NEAR_FULL;
    logic [TRIGGER_ID_WIDTH-1:0] TRIGGER_DATA;
    logic                        TRIGGER_DATA_VALID;
    logic                        TRIGGER_DATA_READY;
    logic                        TRIGGER_ABORT;
    logic [15:0]                 ABORT_CNT;

    modport master (
        input  TLU_MODE, TIMEOUT, TLU_TRIGGER, TLU_TRIGGER_DATA, CMD_READY,
               CMD_EXT_START_ENABLE, FIFO_NEAR_FULL, TRIGGER_DATA_READY,
        output TLU_BUSY, TLU_CLOCK, CMD_EXT_START_FLAG, TRIGGER_DATA,
               TRIGGER_DATA_VALID, TRIGGER_ABORT, ABORT_CNT
    );

    modport slave (
        output TLU_MODE, TIMEOUT, TLU_TRIGGER, TLU_TRIGGER_DATA, CMD_READY,
               CMD_EXT_START_ENABLE, FIFO_NEAR_FULL, TRIGGER_DATA_READY,
        input  TLU_BUSY, TLU_CLOCK, CMD_EXT_START_FLAG, TRIGGER_DATA,
               TRIGGER_DATA_VALID, TRIGGER_ABORT, ABORT_CNT
    );
endinterface

// File: rtl/tlu_trigger_handshake_fsm.sv
// TLU trigger controller: edge detect, command start, optional TLU handshake with
// serial trigger-number readout, and valid/ready hand-off to the readout FIFO.
//
// state                 | meaning
// IDLE                  | waiting for an accepted trigger rising edge
// SEND_COMMAND          | one-cycle start pulse, internal trigger number advanced
// WAIT_FOR_TRIGGER_LOW  | TLU handshake: wait for trigger release, with timeout
// RECEIVE_DATA          | clocking the trigger number out of the TLU, LSB first
// WAIT_FOR_READOUT      | trigger number offered to readout (valid/ready)
// WAIT_FOR_CMD          | waiting for the command FSM to return idle
module tlu_trigger_handshake_fsm #(
    parameter int TRIGGER_ID_WIDTH = 15,
    parameter int TIMEOUT_WIDTH    = 8,
    parameter int DIVIDER          = 4
) (
    input logic CLK,
    input logic RESET,
    tlu_trigger_handshake_fsm_if.master bus
);
    localparam int W     = TRIGGER_ID_WIDTH;
    localparam int DIV_W = $clog2(2 * DIVIDER);
    localparam int BIT_W = $clog2(TRIGGER_ID_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * DIVIDER - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIVIDER);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TRIGGER_ID_WIDTH - 1);

    localparam logic [2:0] IDLE                 = 3'd0;
    localparam logic [2:0] SEND_COMMAND         = 3'd1;
    localparam logic [2:0] WAIT_FOR_TRIGGER_LOW = 3'd2;
    localparam logic [2:0] RECEIVE_DATA         = 3'd3;
    localparam logic [2:0] WAIT_FOR_READOUT     = 3'd4;
    localparam logic [2:0] WAIT_FOR_CMD         = 3'd5;

    logic [2:0]               state, state_nxt;
    logic                     trig_q;
    logic                     accept, rise, abort_hit;
    logic                     last_low, last_bit;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic [W-1:0]             trig_cnt, trig_cnt_inc;
    logic [W-1:0]             shift_reg, shift_in;
    logic [DIV_W-1:0]         div_cnt, div_nxt;
    logic [BIT_W-1:0]         bit_cnt;

    logic                     busy_q, tlu_clk_q, start_q, valid_q, abort_q;
    logic [W-1:0]             data_q;
    logic [15:0]              abort_cnt_q;

    assign accept    = bus.CMD_READY & bus.CMD_EXT_START_ENABLE & ~bus.FIFO_NEAR_FULL;
    assign rise      = bus.TLU_TRIGGER & ~trig_q;
    assign abort_hit = bus.TLU_TRIGGER && (bus.TIMEOUT != '0)
                       && (tmo_cnt == bus.TIMEOUT - TIMEOUT_WIDTH'(1));

    // The TLU clock divider runs down from 2*DIVIDER-1; the upper half is the high phase
    // and zero is the last low cycle, where the serial bit is sampled.
    assign last_low     = (div_cnt == '0);
    assign last_bit     = (bit_cnt == BIT_LAST);
    assign div_nxt      = (state != RECEIVE_DATA || last_low) ? DIV_LAST : div_cnt - DIV_W'(1);
    assign trig_cnt_inc = trig_cnt + W'(1);
    assign shift_in     = (shift_reg >> 1) | (W'(bus.TLU_TRIGGER_DATA) << (W - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (rise && accept) state_nxt = SEND_COMMAND;
            SEND_COMMAND:
                case (bus.TLU_MODE)
                    2'b00:   state_nxt = WAIT_FOR_CMD;
                    2'b01:   state_nxt = WAIT_FOR_READOUT;
                    default: state_nxt = WAIT_FOR_TRIGGER_LOW;
                endcase
            WAIT_FOR_TRIGGER_LOW:
                if (abort_hit)             state_nxt = IDLE;
                else if (!bus.TLU_TRIGGER) state_nxt = bus.TLU_MODE[0] ? RECEIVE_DATA
                                                                       : WAIT_FOR_READOUT;
            RECEIVE_DATA:
                if (last_low && last_bit) state_nxt = WAIT_FOR_READOUT;
            WAIT_FOR_READOUT:
                if (bus.TRIGGER_DATA_READY) state_nxt = WAIT_FOR_CMD;
            WAIT_FOR_CMD:
                if (bus.CMD_READY) state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            trig_q      <= 1'b0;
            tmo_cnt     <= '0;
            trig_cnt    <= '0;
            shift_reg   <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            busy_q      <= 1'b1;
            tlu_clk_q   <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            abort_q     <= 1'b0;
            data_q      <= '0;
            abort_cnt_q <= '0;
        end else begin
            state     <= state_nxt;
            trig_q    <= bus.TLU_TRIGGER;
            start_q   <= (state == IDLE) && rise && accept;
            abort_q   <= (state == WAIT_FOR_TRIGGER_LOW) && abort_hit;
            valid_q   <= (state_nxt == WAIT_FOR_READOUT);
            busy_q    <= bus.TLU_MODE[1] && ((state_nxt != IDLE) || !accept);
            tlu_clk_q <= (state_nxt == RECEIVE_DATA) && (div_nxt >= DIV_HALF);
            div_cnt   <= div_nxt;

            if (state == WAIT_FOR_TRIGGER_LOW) tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
            else                               tmo_cnt <= '0;

            if (state != RECEIVE_DATA) bit_cnt <= '0;
            else if (last_low)         bit_cnt <= bit_cnt + BIT_W'(1);

            if (state == RECEIVE_DATA && last_low) shift_reg <= shift_in;

            if (state == SEND_COMMAND) begin
                trig_cnt <= trig_cnt_inc;
                data_q   <= trig_cnt_inc;
            end else if (state == RECEIVE_DATA && last_low && last_bit) begin
                data_q   <= shift_in;
            end

            if (state == WAIT_FOR_TRIGGER_LOW && abort_hit && abort_cnt_q != 16'hFFFF)
                abort_cnt_q <= abort_cnt_q + 16'd1;
        end
    end

    assign bus.TLU_BUSY           = busy_q;
    assign bus.TLU_CLOCK          = tlu_clk_q;
    assign bus.CMD_EXT_START_FLAG = start_q;
    assign bus.TRIGGER_DATA       = data_q;
    assign bus.TRIGGER_DATA_VALID = valid_q;
    assign bus.TRIGGER_ABORT      = abort_q;
    assign bus.ABORT_CNT          = abort_cnt_q;
endmodule

// File: tb/tb_tlu_trigger_handshake_fsm.sv
// Directed bench for tlu_trigger_handshake_fsm; includes a small TLU serial-ID model
// that presents the next bit on each rising TLU_CLOCK.
module tb_tlu_trigger_handshake_fsm;
    localparam int W  = 15;
    localparam int TW = 8;
    localparam int D  = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    int errors = 0;
    int checks = 0;

    int         clk_pulses = 0;
    int         ser_idx = 0;
    logic [W-1:0] ser_id = '0;
    logic       clk_prev = 1'b0;
    int         flag_cnt = 0;
    int         valid_cnt = 0;
    int         abort_seen = 0;

    tlu_trigger_handshake_fsm_if #(.TRIGGER_ID_WIDTH(W), .TIMEOUT_WIDTH(TW)) bus ();

    tlu_trigger_handshake_fsm #(
        .TRIGGER_ID_WIDTH(W),
        .TIMEOUT_WIDTH(TW),
        .DIVIDER(D)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // One clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
        if (bus.TLU_CLOCK && !clk_prev) begin
            clk_pulses++;
            bus.TLU_TRIGGER_DATA = (ser_idx < W) ? ser_id[ser_idx] : 1'b0;
            ser_idx++;
        end
        clk_prev = bus.TLU_CLOCK;
        flag_cnt += int'(bus.CMD_EXT_START_FLAG);
        valid_cnt += int'(bus.TRIGGER_DATA_VALID);
        abort_seen += int'(bus.TRIGGER_ABORT);
    endtask

    task automatic set_defaults(input logic [1:0] mode);
        bus.TLU_MODE             = mode;
        bus.TIMEOUT              = '0;
        bus.TLU_TRIGGER          = 1'b0;
        bus.TLU_TRIGGER_DATA     = 1'b0;
        bus.CMD_READY            = 1'b1;
        bus.CMD_EXT_START_ENABLE = 1'b1;
        bus.FIFO_NEAR_FULL       = 1'b0;
        bus.TRIGGER_DATA_READY   = 1'b1;
    endtask

    task automatic do_reset(input logic [1:0] mode);
        set_defaults(mode);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        clk_prev = 1'b0; flag_cnt = 0; valid_cnt = 0; abort_seen = 0;
        clk_pulses = 0; ser_idx = 0;
        step();
    endtask

    task automatic test_reset();
        set_defaults(2'b10);
        #2 RESET = 1'b1;
        #1;
        checks++; if (bus.TLU_BUSY !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", bus.TLU_BUSY); end
        checks++; if (bus.TLU_CLOCK !== 1'b0) begin errors++; $display("FAIL rst_tlu_clock got=%b exp=0", bus.TLU_CLOCK); end
        checks++; if (bus.CMD_EXT_START_FLAG !== 1'b0) begin errors++; $display("FAIL rst_flag got=%b exp=0", bus.CMD_EXT_START_FLAG); end
        checks++; if (bus.TRIGGER_DATA !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", bus.TRIGGER_DATA); end
        checks++; if (bus.TRIGGER_DATA_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.TRIGGER_DATA_VALID); end
        checks++; if (bus.TRIGGER_ABORT !== 1'b0) begin errors++; $display("FAIL rst_abort got=%b exp=0", bus.TRIGGER_ABORT); end
        checks++; if (bus.ABORT_CNT !== 16'd0) begin errors++; $display("FAIL rst_abort_cnt got=%h exp=0", bus.ABORT_CNT); end
        @(posedge CLK);
        #1;
        checks++; if (bus.TLU_BUSY !== 1'b1) begin errors++; $display("FAIL rst_busy_held got=%b exp=1", bus.TLU_BUSY); end
        RESET = 1'b0;
        step();
        checks++; if (bus.TLU_BUSY !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%b exp=0", bus.TLU_BUSY); end
    endtask

    task automatic test_mode00();
        do_reset(2'b00);
        checks++; if (bus.TLU_BUSY !== 1'b0) begin errors++; $display("FAIL m00_busy_idle got=%b exp=0", bus.TLU_BUSY); end
        bus.TLU_TRIGGER = 1'b1;
        step();
        checks++; if (bus.CMD_EXT_START_FLAG !== 1'b1) begin errors++; $display("FAIL m00_flag got=%b exp=1", bus.CMD_EXT_START_FLAG); end
        checks++; if (bus.TLU_BUSY !== 1'b0) begin errors++; $display("FAIL m00_busy got=%b exp=0", bus.TLU_BUSY); end
        bus.CMD_READY = 1'b0;
        step();
        checks++; if (bus.CMD_EXT_START_FLAG !== 1'b0) begin errors++; $display("FAIL m00_flag_one_cycle got=%b exp=0", bus.CMD_EXT_START_FLAG); end
        bus.TLU_TRIGGER = 1'b0; step();
        bus.TLU_TRIGGER = 1'b1; step();
        bus.CMD_READY = 1'b1; step();
        step(); step();
        checks++; if (flag_cnt !== 1) begin errors++; $display("FAIL m00_edge_not_queued flags=%0d exp=1", flag_cnt); end
        bus.TLU_TRIGGER = 1'b0; step();
        bus.TLU_TRIGGER = 1'b1; step();
        checks++; if (bus.CMD_EXT_START_FLAG !== 1'b1) begin errors++; $display("FAIL m00_back_in_idle got=%b exp=1", bus.CMD_EXT_START_FLAG); end
        step(); step();
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL m00_no_valid count=%0d exp=0", valid_cnt); end
        checks++; if (bus.TLU_BUSY !== 1'b0) begin errors++; $display("FAIL m00_busy_end got=%b exp=0", bus.TLU_BUSY); end
    endtask

    task automatic test_mode10_back_to_back();
        do_reset(2'b10);
        for (int i = 1; i <= 3; i++) begin
            checks++; if (bus.TLU_BUSY !== 1'b0) begin errors++; $display("FAIL m10_idle_busy[%0d] got=%b exp=0", i, bus.TLU_BUSY); end
            bus.TLU_TRIGGER = 1'b1;
            step();
            checks++; if (bus.CMD_EXT_START_FLAG !== 1'b1) begin errors++; $display("FAIL m10_flag[%0d] got=%b exp=1", i, bus.CMD_EXT_START_FLAG); end
            checks++; if (bus.TLU_BUSY !== 1'b1) begin errors++; $display("FAIL m10_busy_edge[%0d] got=%b exp=1", i, bus.TLU_BUSY); end
            step();
            checks++; if (bus.TRIGGER_DATA_VALID !== 1'b0) begin errors++; $display("FAIL m10_valid_early[%0d] got=%b exp=0", i, bus.TRIGGER_DATA_VALID); end
            bus.TLU_TRIGGER = 1'b0;
            step();
            checks++; if (bus.TRIGGER_DATA_VALID !== 1'b1) begin errors++; $display("FAIL m10_valid[%0d] got=%b exp=1", i, bus.TRIGGER_DATA_VALID); end
            checks++; if (bus.TRIGGER_DATA !== W'(i)) begin errors++; $display("FAIL m10_data[%0d] got=%h exp=%h", i, bus.TRIGGER_DATA, W'(i)); end
            step();
            checks++; if (bus.TRIGGER_DATA_VALID !== 1'b0) begin errors++; $display("FAIL m10_valid_drop[%0d] got=%b exp=0", i, bus.TRIGGER_DATA_VALID); end
            checks++; if (bus.TLU_BUSY !== 1'b1) begin errors++; $display("FAIL m10_busy_wait_cmd[%0d] got=%b exp=1", i, bus.TLU_BUSY); end
            step();
            checks++; if (bus.TLU_BUSY !== 1'b0) begin errors++; $display("FAIL m10_busy_idle_again[%0d] got=%b exp=0", i, bus.TLU_BUSY); end
        end
    endtask

    task automatic test_mode11_serial();
        int lat;
        logic [W-1:0] held;
        do_reset(2'b11);
        bus.TRIGGER_DATA_READY = 1'b0;
        bus.TLU_TRIGGER = 1'b1;
        step(); step();
        bus.TLU_TRIGGER = 1'b0;
        ser_id = 15'h2A5B; ser_idx = 0; clk_pulses = 0;
        step();
        checks++; if (bus.TLU_CLOCK !== 1'b1) begin errors++; $display("FAIL m11_clock_rise got=%b exp=1", bus.TLU_CLOCK); end
        lat = 0;
        while (!bus.TRIGGER_DATA_VALID && lat < 300) begin step(); lat++; end
        checks++; if (lat != 2 * D * W) begin errors++; $display("FAIL m11_valid_latency got=%0d exp=%0d", lat, 2 * D * W); end
        checks++; if (bus.TRIGGER_DATA !== 15'h2A5B) begin errors++; $display("FAIL m11_data got=%h exp=2a5b", bus.TRIGGER_DATA); end
        checks++; if (clk_pulses != W) begin errors++; $display("FAIL m11_clock_pulses got=%0d exp=%0d", clk_pulses, W); end
        checks++; if (bus.TLU_CLOCK !== 1'b0) begin errors++; $display("FAIL m11_clock_low got=%b exp=0", bus.TLU_CLOCK); end
        held = bus.TRIGGER_DATA;
        step(); step();
        checks++; if (bus.TRIGGER_DATA_VALID !== 1'b1) begin errors++; $display("FAIL m11_valid_hold got=%b exp=1", bus.TRIGGER_DATA_VALID); end
        checks++; if (bus.TRIGGER_DATA !== 15'h2A5B) begin errors++; $display("FAIL m11_data_hold got=%h exp=2a5b", bus.TRIGGER_DATA); end
        bus.TRIGGER_DATA_READY = 1'b1;
        step();
        checks++; if (bus.TRIGGER_DATA_VALID !== 1'b0) begin errors++; $display("FAIL m11_valid_drop got=%b exp=0", bus.TRIGGER_DATA_VALID); end
        step();
        checks++; if (bus.TLU_BUSY !== 1'b0) begin errors++; $display("FAIL m11_busy_idle got=%b exp=0", bus.TLU_BUSY); end
        checks++; if (clk_pulses != W) begin errors++; $display("FAIL m11_no_extra_pulses got=%0d exp=%0d", clk_pulses, W); end
        if (held !== 15'h2A5B) ser_id = '0;
    endtask

    task automatic test_timeout();
        int first_abort;
        logic busy13;
        do_reset(2'b10);
        bus.TIMEOUT = 8'd10;
        bus.TLU_TRIGGER = 1'b1;
        first_abort = 0;
        busy13 = 1'bx;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (bus.TRIGGER_ABORT && first_abort == 0) first_abort = k;
            if (k == 13) busy13 = bus.TLU_BUSY;
        end
        checks++; if (first_abort != 12) begin errors++; $display("FAIL tmo_abort_cycle got=%0d exp=12", first_abort); end
        checks++; if (abort_seen != 1) begin errors++; $display("FAIL tmo_abort_width got=%0d exp=1", abort_seen); end
        checks++; if (bus.ABORT_CNT !== 16'd1) begin errors++; $display("FAIL tmo_abort_cnt got=%0d exp=1", bus.ABORT_CNT); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL tmo_no_valid got=%0d exp=0", valid_cnt); end
        checks++; if (busy13 !== 1'b0) begin errors++; $display("FAIL tmo_busy_after got=%b exp=0", busy13); end
        checks++; if (flag_cnt != 1) begin errors++; $display("FAIL tmo_flags got=%0d exp=1", flag_cnt); end
        bus.TLU_TRIGGER = 1'b0; step();
        bus.TLU_TRIGGER = 1'b1; step();
        step();
        checks++; if (bus.TRIGGER_DATA !== W'(2)) begin errors++; $display("FAIL tmo_next_data got=%h exp=2", bus.TRIGGER_DATA); end
        bus.TLU_TRIGGER = 1'b0;
        step();
        checks++; if (bus.TRIGGER_DATA_VALID !== 1'b1) begin errors++; $display("FAIL tmo_next_valid got=%b exp=1", bus.TRIGGER_DATA_VALID); end
    endtask

    task automatic test_blocked();
        do_reset(2'b10);
        for (int c = 0; c < 2; c++) begin
            if (c == 0) bus.FIFO_NEAR_FULL = 1'b1;
            else        bus.CMD_EXT_START_ENABLE = 1'b0;
            step();
            checks++; if (bus.TLU_BUSY !== 1'b1) begin errors++; $display("FAIL blk_busy[%0d] got=%b exp=1", c, bus.TLU_BUSY); end
            bus.TLU_TRIGGER = 1'b1;
            step();
            checks++; if (bus.CMD_EXT_START_FLAG !== 1'b0) begin errors++; $display("FAIL blk_flag[%0d] got=%b exp=0", c, bus.CMD_EXT_START_FLAG); end
            step(); step();
            bus.FIFO_NEAR_FULL = 1'b0;
            bus.CMD_EXT_START_ENABLE = 1'b1;
            step();
            checks++; if (bus.TLU_BUSY !== 1'b0) begin errors++; $display("FAIL blk_unblock_busy[%0d] got=%b exp=0", c, bus.TLU_BUSY); end
            step(); step();
            checks++; if (flag_cnt != 0) begin errors++; $display("FAIL blk_no_replay[%0d] got=%0d exp=0", c, flag_cnt); end
            bus.TLU_TRIGGER = 1'b0;
            step();
        end
        bus.TLU_TRIGGER = 1'b1;
        step();
        checks++; if (bus.CMD_EXT_START_FLAG !== 1'b1) begin errors++; $display("FAIL blk_fresh_edge got=%b exp=1", bus.CMD_EXT_START_FLAG); end
    endtask

    task automatic test_reset_mid_transfer();
        int lat;
        do_reset(2'b11);
        bus.TLU_TRIGGER = 1'b1;
        step(); step();
        bus.TLU_TRIGGER = 1'b0;
        ser_id = 15'h1234; ser_idx = 0; clk_pulses = 0;
        step();
        for (int i = 0; i < 200 && ser_idx < 8; i++) step();
        checks++; if (ser_idx != 8) begin errors++; $display("FAIL rmid_reach_bit7 got=%0d exp=8", ser_idx); end
        #3 RESET = 1'b1;
        #1;
        checks++; if (bus.TLU_BUSY !== 1'b1) begin errors++; $display("FAIL rmid_busy got=%b exp=1", bus.TLU_BUSY); end
        checks++; if (bus.TLU_CLOCK !== 1'b0) begin errors++; $display("FAIL rmid_clock got=%b exp=0", bus.TLU_CLOCK); end
        checks++; if (bus.TRIGGER_DATA !== '0) begin errors++; $display("FAIL rmid_data got=%h exp=0", bus.TRIGGER_DATA); end
        checks++; if (bus.TRIGGER_DATA_VALID !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.TRIGGER_DATA_VALID); end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        clk_prev = 1'b0;
        step();
        bus.TLU_TRIGGER = 1'b1;
        step();
        checks++; if (bus.CMD_EXT_START_FLAG !== 1'b1) begin errors++; $display("FAIL rmid_new_flag got=%b exp=1", bus.CMD_EXT_START_FLAG); end
        step();
        checks++; if (bus.TRIGGER_DATA !== W'(1)) begin errors++; $display("FAIL rmid_counter_restart got=%h exp=1", bus.TRIGGER_DATA); end
        bus.TLU_TRIGGER = 1'b0;
        ser_id = 15'h5A3C; ser_idx = 0; clk_pulses = 0;
        step();
        lat = 0;
        while (!bus.TRIGGER_DATA_VALID && lat < 300) begin step(); lat++; end
        checks++; if (lat != 2 * D * W) begin errors++; $display("FAIL rmid_latency got=%0d exp=%0d", lat, 2 * D * W); end
        checks++; if (bus.TRIGGER_DATA !== 15'h5A3C) begin errors++; $display("FAIL rmid_data_after got=%h exp=5a3c", bus.TRIGGER_DATA); end
        checks++; if (clk_pulses != W) begin errors++; $display("FAIL rmid_pulses got=%0d exp=%0d", clk_pulses, W); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode00();
        test_mode10_back_to_back();
        test_mode11_serial();
        test_timeout();
        test_blocked();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
